// File: rtl/trigger_pkg.sv
// Types and helpers shared by the trigger RX, TX and pulse-generation blocks.
// A timestamp is a TAI second plus a cycle count within that second and a fine delay.
package trigger_pkg;

  typedef struct packed {
    logic [39:0] tai;
    logic [27:0] cycles;
    logic [11:0] fine;
  } t_trig_ts;

  // True when time a is strictly earlier than time b; fine delay does not take part.
  function automatic logic ts_before(input logic [39:0] a_tai,
                                     input logic [27:0] a_cycles,
                                     input logic [39:0] b_tai,
                                     input logic [27:0] b_cycles);
    if (a_tai != b_tai) begin
      return a_tai < b_tai;
    end
    return a_cycles < b_cycles;
  endfunction

endpackage

// File: rtl/trigger_ts_fifo.sv
// Small synchronous FIFO of trigger timestamps with flush, full and empty flags.
// The head entry is readable combinationally so it can be compared in the cycle it appears.
module trigger_ts_fifo
  import trigger_pkg::*;
#(
  parameter int unsigned g_depth = 4
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  logic     flush_i,
  input  logic     wr_en_i,
  input  t_trig_ts wr_data_i,
  input  logic     rd_en_i,
  output t_trig_ts rd_data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned c_aw = $clog2(g_depth);

  t_trig_ts        mem_q [g_depth];
  logic [c_aw:0]   wr_ptr_q, wr_ptr_d;
  logic [c_aw:0]   rd_ptr_q, rd_ptr_d;
  logic            wr_fire;
  logic            rd_fire;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                   (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);

  assign rd_fire = rd_en_i && !empty_o;
  assign wr_fire = wr_en_i && (!full_o || rd_fire);

  assign rd_data_o = mem_q[rd_ptr_q[c_aw-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{c_aw{1'b0}}, wr_fire};
    rd_ptr_d = rd_ptr_q + {{c_aw{1'b0}}, rd_fire};
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire && !flush_i) begin
      mem_q[wr_ptr_q[c_aw-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/trigger_pulse_gen.sv
// Trigger output stage: queues scheduled timestamps, fires a DIO pulse when WR time
// reaches the queue head, drops late entries as misses and keeps pulse/miss statistics.
module trigger_pulse_gen
  import trigger_pkg::*;
#(
  parameter int unsigned g_fifo_depth = 4,
  parameter int unsigned g_clk_freq   = 125000000,
  parameter int unsigned g_width_bits = 16
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_n_i,
  input  logic                    ts_valid_i,
  output logic                    ts_ready_o,
  input  logic [39:0]             ts_tai_i,
  input  logic [27:0]             ts_cycles_i,
  input  logic [11:0]             ts_fine_i,
  input  logic [39:0]             tm_tai_i,
  input  logic [27:0]             tm_cycles_i,
  input  logic                    tm_time_valid_i,
  input  logic                    enable_i,
  input  logic [g_width_bits-1:0] width_i,
  input  logic                    cnt_rst_i,
  output logic                    pulse_o,
  output logic [11:0]             pulse_fine_o,
  output logic                    miss_o,
  output logic [31:0]             pulse_cnt_o,
  output logic [31:0]             miss_cnt_o
);

  localparam logic [0:0]  ST_IDLE       = 1'b0;
  localparam logic [0:0]  ST_ACTIVE     = 1'b1;
  localparam logic [27:0] c_cycles_wrap = 28'(g_clk_freq);

  t_trig_ts push_ts;
  t_trig_ts head_ts;
  logic     fifo_full;
  logic     fifo_empty;
  logic     push;
  logic     pop;
  logic     cmp_en;
  logic     head_due;
  logic     head_late;
  logic     fire;
  logic     miss;

  logic [0:0]              state_q, state_d;
  logic [g_width_bits-1:0] width_cnt_q, width_cnt_d;
  logic [g_width_bits-1:0] width_load;
  logic [11:0]             fine_q, fine_d;
  logic                    miss_q, miss_d;
  logic [31:0]             pulse_cnt_q, pulse_cnt_d;
  logic [31:0]             miss_cnt_q, miss_cnt_d;

  // While disabled the queue is flushed every cycle, so upstream is never stalled.
  assign ts_ready_o = !fifo_full || !enable_i;
  assign push       = ts_valid_i && ts_ready_o && enable_i;

  always_comb begin
    push_ts        = '0;
    push_ts.tai    = ts_tai_i;
    push_ts.cycles = ts_cycles_i;
    push_ts.fine   = ts_fine_i;
  end

  trigger_ts_fifo #(
    .g_depth (g_fifo_depth)
  ) u_fifo (
    .clk_i     (clk_sys_i),
    .rst_n_i   (rst_n_i),
    .flush_i   (!enable_i),
    .wr_en_i   (push),
    .wr_data_i (push_ts),
    .rd_en_i   (pop),
    .rd_data_o (head_ts),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign cmp_en   = enable_i && tm_time_valid_i && !fifo_empty;
  assign head_due = (head_ts.tai == tm_tai_i) && (head_ts.cycles == tm_cycles_i);
  // A cycles field beyond the second's wrap point can never match, so it is dropped at once.
  assign head_late = ts_before(head_ts.tai, head_ts.cycles, tm_tai_i, tm_cycles_i) ||
                     (head_ts.cycles >= c_cycles_wrap);

  assign fire   = cmp_en && head_due;
  assign miss   = cmp_en && head_late && !head_due;
  assign pop    = fire || miss;
  assign miss_d = miss;

  assign width_load = (width_i == '0) ? g_width_bits'(1) : width_i;

  always_comb begin
    state_d     = state_q;
    width_cnt_d = width_cnt_q;
    fine_d      = fine_q;
    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          state_d     = ST_ACTIVE;
          width_cnt_d = width_load;
          fine_d      = head_ts.fine;
        end
      end
      ST_ACTIVE: begin
        // A fire during an active pulse stretches it rather than restarting it.
        if (fire) begin
          width_cnt_d = width_load;
          fine_d      = head_ts.fine;
        end else if (width_cnt_q == g_width_bits'(1)) begin
          state_d = ST_IDLE;
        end else begin
          width_cnt_d = width_cnt_q - g_width_bits'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pulse_cnt_d = pulse_cnt_q + {31'd0, fire};
    miss_cnt_d  = miss_cnt_q + {31'd0, miss};
    if (cnt_rst_i) begin
      pulse_cnt_d = '0;
      miss_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      width_cnt_q <= '0;
      fine_q      <= '0;
      miss_q      <= 1'b0;
      pulse_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      width_cnt_q <= width_cnt_d;
      fine_q      <= fine_d;
      miss_q      <= miss_d;
      pulse_cnt_q <= pulse_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign pulse_o      = (state_q == ST_ACTIVE);
  assign pulse_fine_o = fine_q;
  assign miss_o       = miss_q;
  assign pulse_cnt_o  = pulse_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;

endmodule
